// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with any depth, live thresholds, occupancy and flush.
// Optional sticky error flags when SYNC_FIFO_STICKY_ERR_EN is defined.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  input  logic [CW-1:0]         af_thresh,
  input  logic [CW-1:0]         ae_thresh,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
`ifdef SYNC_FIFO_STICKY_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_go, rd_go;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = !full && (count_q >= af_thresh);
  assign almostempty = !empty && (count_q <= ae_thresh);

  always_comb begin
    wr_go    = wr_en && !full && !flush;
    rd_go    = rd_en && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    wr_ack_d = wr_go;
    ovf_d    = wr_en && full && !flush;
    udf_d    = rd_en && empty && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_go) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_go) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dout_d   = mem_q[rd_ptr_q];
      end
      unique case ({wr_go, rd_go})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign count     = count_q;
  assign data_out  = dout_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

`ifdef SYNC_FIFO_STICKY_ERR_EN
  logic ovf_s_q, ovf_s_d;
  logic udf_s_q, udf_s_d;

  // Set dominates a coincident clear.
  always_comb begin
    ovf_s_d = ovf_d || (ovf_s_q && !err_clr);
    udf_s_d = udf_d || (udf_s_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_s_q <= 1'b0;
      udf_s_q <= 1'b0;
    end else begin
      ovf_s_q <= ovf_s_d;
      udf_s_q <= udf_s_d;
    end
  end

  assign ovf_sticky = ovf_s_q;
  assign udf_sticky = udf_s_q;
`endif

endmodule
